// File: rtl/router_pkg.sv
// Shared widths, precision/state enums and lane helper for the result writer.
package router_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH      = 8;
  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned COUNT_WIDTH     = 12;
  localparam int unsigned LANE_WIDTH      = 5;

  typedef enum logic [1:0] {
    P_8B = 2'b00,
    P_4B = 2'b01,
    P_2B = 2'b10
  } p_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } wr_state_e;

  // Mode 2'b11 falls back to 8-bit packing.
  function automatic logic [5:0] lanes_per_word(input logic [1:0] mode);
    case (mode)
      P_4B:    return 6'd16;
      P_2B:    return 6'd32;
      default: return 6'd8;
    endcase
  endfunction

endpackage

// File: rtl/result_packer.sv
// Packs accepted elements into a word at the selected precision; zero-pads
// naturally since the pack register is cleared at each word boundary.
module result_packer
  import router_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       flush,
  input  logic                       accept,
  input  logic [1:0]                 mode,
  input  logic [DATA_WIDTH-1:0]      elem,
  output logic [SRAM_DATA_WIDTH-1:0] word,
  output logic                       word_done,
  output logic [SRAM_DATA_WIDTH-1:0] pack
);

  logic [SRAM_DATA_WIDTH-1:0] pack_q, pack_d, pack_ins;
  logic [LANE_WIDTH-1:0]      lane_q, lane_d;
  logic                       last_lane;

  always_comb begin
    pack_ins = pack_q;
    case (mode)
      P_4B:    pack_ins[{lane_q[3:0], 2'b00} +: 4]  = elem[3:0];
      P_2B:    pack_ins[{lane_q, 1'b0} +: 2]        = elem[1:0];
      default: pack_ins[{lane_q[2:0], 3'b000} +: 8] = elem[7:0];
    endcase

    last_lane = ({1'b0, lane_q} == (lanes_per_word(mode) - 6'd1));
    word_done = accept && last_lane;

    pack_d = pack_q;
    lane_d = lane_q;
    if (accept) begin
      if (last_lane) begin
        pack_d = '0;
        lane_d = '0;
      end else begin
        pack_d = pack_ins;
        lane_d = lane_q + LANE_WIDTH'(1);
      end
    end
  end

  assign word = pack_ins;
  assign pack = pack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q <= '0;
      lane_q <= '0;
    end else if (clear || flush) begin
      pack_q <= '0;
      lane_q <= '0;
    end else begin
      pack_q <= pack_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/result_sram.sv
// Output SRAM: one write port, one host read port with a single cycle of latency.
module result_sram
  import router_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [SRAM_DATA_WIDTH-1:0] wdata,
  input  logic                       re,
  input  logic [ADDR_WIDTH-1:0]      raddr,
  output logic [SRAM_DATA_WIDTH-1:0] rdata,
  output logic                       rvalid
);

  logic [SRAM_DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];
  logic [SRAM_DATA_WIDTH-1:0] rdata_q;
  logic                       rvalid_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/result_writer.sv
// Packs serial PE results into SRAM words and exposes a host read port.
// Optional macro RESULT_WRITER_RELU_EN clamps negative elements to zero.
module result_writer
  import router_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_clear,
  input  logic                       i_route_en,
  input  logic [1:0]                 i_p_mode,
  input  logic [ADDR_WIDTH-1:0]      i_start_addr,
  input  logic [COUNT_WIDTH-1:0]     i_route_size,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_data_valid,
  output logic                       o_ready,
  output logic                       o_route_done,
  output logic [ADDR_WIDTH-1:0]      o_words_written,
  input  logic                       i_sram_read_en,
  input  logic [ADDR_WIDTH-1:0]      i_read_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
  output logic                       o_data_out_valid
);

  wr_state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]      start_addr_q, word_cnt_q;
  logic [COUNT_WIDTH-1:0]     size_q, elem_cnt_q;
  logic [1:0]                 mode_q;
  logic                       wr_pending_q;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q;

  logic                       accept, last_elem, word_done, sram_we;
  logic [SRAM_DATA_WIDTH-1:0] packed_word, pack_word, sram_wdata;
  logic [ADDR_WIDTH-1:0]      sram_waddr;
  logic [DATA_WIDTH-1:0]      elem;

`ifdef RESULT_WRITER_RELU_EN
  assign elem = i_data[DATA_WIDTH-1] ? '0 : i_data;
`else
  assign elem = i_data;
`endif

  assign accept    = (state_q == StRun) && i_data_valid && !i_reg_clear;
  assign o_ready   = (state_q == StRun) && !i_reg_clear;
  assign last_elem = accept && ((elem_cnt_q + COUNT_WIDTH'(1)) == size_q);

  // FLUSH drains either the word completed by the last element or the partial word.
  assign sram_we    = !i_reg_clear && (wr_pending_q || (state_q == StFlush));
  assign sram_wdata = wr_pending_q ? wr_data_q : pack_word;
  assign sram_waddr = start_addr_q + word_cnt_q;

  assign o_route_done    = (state_q == StDone);
  assign o_words_written = word_cnt_q;

  always_comb begin
    state_d = state_q;
    if (i_reg_clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_route_en) begin
            state_d = (i_route_size == '0) ? StDone : StRun;
          end
        end
        StRun:   if (last_elem) state_d = StFlush;
        StFlush: state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      start_addr_q <= '0;
      size_q       <= '0;
      mode_q       <= '0;
      elem_cnt_q   <= '0;
      word_cnt_q   <= '0;
      wr_pending_q <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (i_reg_clear) begin
        elem_cnt_q   <= '0;
        word_cnt_q   <= '0;
        wr_pending_q <= 1'b0;
      end else begin
        if ((state_q == StIdle) && i_route_en) begin
          start_addr_q <= i_start_addr;
          size_q       <= i_route_size;
          mode_q       <= i_p_mode;
          elem_cnt_q   <= '0;
          word_cnt_q   <= '0;
        end
        if (accept) begin
          elem_cnt_q <= elem_cnt_q + COUNT_WIDTH'(1);
        end
        if (sram_we) begin
          word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
        end
        if (word_done) begin
          wr_pending_q <= 1'b1;
          wr_data_q    <= packed_word;
        end else if (sram_we) begin
          wr_pending_q <= 1'b0;
        end
      end
    end
  end

  result_packer u_packer (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (i_reg_clear),
    .flush     (state_q == StFlush),
    .accept    (accept),
    .mode      (mode_q),
    .elem      (elem),
    .word      (packed_word),
    .word_done (word_done),
    .pack      (pack_word)
  );

  result_sram u_sram (
    .clk    (i_clk),
    .rst    (i_rst),
    .we     (sram_we),
    .waddr  (sram_waddr),
    .wdata  (sram_wdata),
    .re     (i_sram_read_en),
    .raddr  (i_read_addr),
    .rdata  (o_data_out),
    .rvalid (o_data_out_valid)
  );

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: table of routes plus latency, size-0 and clear sequences.
module tb_result_writer;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_clear = 1'b0;
  logic        route_en = 1'b0;
  logic [1:0]  p_mode = 2'b00;
  logic [7:0]  start_addr = '0;
  logic [11:0] route_size = '0;
  logic [7:0]  data = '0;
  logic        data_valid = 1'b0;
  logic        ready, route_done;
  logic [7:0]  words_written;
  logic        sram_read_en = 1'b0;
  logic [7:0]  read_addr = '0;
  logic [63:0] data_out;
  logic        data_out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_writer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_reg_clear      (reg_clear),
    .i_route_en       (route_en),
    .i_p_mode         (p_mode),
    .i_start_addr     (start_addr),
    .i_route_size     (route_size),
    .i_data           (data),
    .i_data_valid     (data_valid),
    .o_ready          (ready),
    .o_route_done     (route_done),
    .o_words_written  (words_written),
    .i_sram_read_en   (sram_read_en),
    .i_read_addr      (read_addr),
    .o_data_out       (data_out),
    .o_data_out_valid (data_out_valid)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  start;
    logic [11:0] size;
    logic [7:0]  d0;
    logic [7:0]  step;
    int          nwords;
    logic [63:0] w0;
    logic [63:0] w1;
  } vec_t;

  vec_t vecs [8];

`ifdef RESULT_WRITER_RELU_EN
  localparam logic [63:0] ReluOne = 64'h0;
  localparam logic [63:0] ReluTwo = 64'h7F00;
`else
  localparam logic [63:0] ReluOne = 64'h80;
  localparam logic [63:0] ReluTwo = 64'h7F80;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_route(input logic [1:0] m, input logic [7:0] a, input logic [11:0] s);
    route_en   = 1'b1;
    p_mode     = m;
    start_addr = a;
    route_size = s;
    tick();
    route_en = 1'b0;
  endtask

  // Drives total elements one per cycle; counts cycles where ready was low for the first n.
  task automatic feed(input logic [7:0] d0, input logic [7:0] step, input int n, input int total,
                      output int stalls);
    logic [7:0] dd;
    stalls = 0;
    for (int i = 0; i < total; i++) begin
      dd         = d0 + 8'(i) * step;
      data_valid = 1'b1;
      data       = dd;
      if (i < n && !ready) stalls++;
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!route_done && k < 20) begin
      tick();
      k++;
    end
    check(name, 64'(route_done), 64'd1);
  endtask

  task automatic clear_pulse();
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [63:0] exp);
    sram_read_en = 1'b1;
    read_addr    = a;
    tick();
    sram_read_en = 1'b0;
    check({name, "_vld"}, 64'(data_out_valid), 64'd1);
    check(name, data_out, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    vecs[0] = '{2'b00, 8'h10, 12'd8,  8'h01, 8'h01, 1, 64'h0807060504030201, 64'h0};
    vecs[1] = '{2'b01, 8'h20, 12'd20, 8'h0F, 8'h00, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF};
    vecs[2] = '{2'b00, 8'hFF, 12'd16, 8'h11, 8'h11, 2, 64'h8877665544332211,
                64'h10FFEEDDCCBBAA99};
    vecs[3] = '{2'b10, 8'h30, 12'd33, 8'h07, 8'h00, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3};
    vecs[4] = '{2'b11, 8'h40, 12'd3,  8'hA1, 8'h01, 1, 64'hA3A2A1, 64'h0};
    vecs[5] = '{2'b01, 8'h50, 12'd3,  8'h12, 8'h11, 1, 64'h432, 64'h0};
    vecs[6] = '{2'b00, 8'h60, 12'd1,  8'h80, 8'h00, 1, ReluOne, 64'h0};
    vecs[7] = '{2'b00, 8'h61, 12'd2,  8'h80, 8'hFF, 1, ReluTwo, 64'h0};

    repeat (3) tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_done", 64'(route_done), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_rvalid", 64'(data_out_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 64'(ready), 64'd0);

    for (int i = 0; i < 8; i++) begin
      start_route(vecs[i].mode, vecs[i].start, vecs[i].size);
      feed(vecs[i].d0, vecs[i].step, int'(vecs[i].size), int'(vecs[i].size) + 2, stalls);
      check($sformatf("v%0d_stalls", i), 64'(stalls), 64'd0);
      wait_done($sformatf("v%0d_done", i));
      check($sformatf("v%0d_ready_done", i), 64'(ready), 64'd0);
      check($sformatf("v%0d_words", i), 64'(words_written), 64'(vecs[i].nwords));
      clear_pulse();
      read_chk($sformatf("v%0d_w0", i), vecs[i].start, vecs[i].w0);
      if (vecs[i].nwords == 2) begin
        read_chk($sformatf("v%0d_w1", i), vecs[i].start + 8'd1, vecs[i].w1);
      end
    end

    // Write latency: word completes in cycle t, counter reflects the write after t+1.
    start_route(2'b00, 8'h70, 12'd8);
    feed(8'h31, 8'h01, 8, 8, stalls);
    check("lat_t_words", 64'(words_written), 64'd0);
    check("lat_t_ready", 64'(ready), 64'd0);
    tick();
    check("lat_t1_words", 64'(words_written), 64'd1);
    wait_done("lat_done");
    clear_pulse();
    read_chk("lat_w0", 8'h70, 64'h3837363534333231);

    // Zero-size route goes straight to DONE; route_en ignored there.
    start_route(2'b00, 8'hA0, 12'd0);
    check("z_done", 64'(route_done), 64'd1);
    check("z_ready", 64'(ready), 64'd0);
    check("z_words", 64'(words_written), 64'd0);
    start_route(2'b00, 8'hA0, 12'd8);
    check("z_ign_done", 64'(route_done), 64'd1);
    check("z_ign_ready", 64'(ready), 64'd0);
    clear_pulse();
    check("z_clr_done", 64'(route_done), 64'd0);

    // Clear mid-route cancels the partial word; valid outside RUN is ignored.
    start_route(2'b00, 8'h10, 12'd8);
    feed(8'hC1, 8'h01, 5, 5, stalls);
    data_valid = 1'b1;
    data       = 8'hEE;
    reg_clear  = 1'b1;
    tick();
    reg_clear = 1'b0;
    check("clr_ready", 64'(ready), 64'd0);
    check("clr_done", 64'(route_done), 64'd0);
    check("clr_words", 64'(words_written), 64'd0);
    repeat (2) tick();
    data_valid = 1'b0;
    check("clr_idle_words", 64'(words_written), 64'd0);
    read_chk("clr_keep", 8'h10, 64'h0807060504030201);
    start_route(2'b00, 8'h90, 12'd8);
    feed(8'h21, 8'h01, 8, 8, stalls);
    wait_done("clr_new_done");
    check("clr_new_words", 64'(words_written), 64'd1);
    clear_pulse();
    read_chk("clr_new_w0", 8'h90, 64'h2827262524232221);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
